// File: rtl/avl_burst_pkg.sv
// Shared widths and FSM encodings for the Avalon-MM burst responder.
package avl_burst_pkg;

    localparam int BURST_W = 5;
    localparam int DATA_W  = 32;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WR_BURST = 2'd1;
    localparam logic [1:0] ST_RD_ISSUE = 2'd2;

endpackage

// File: rtl/avl_rd_pipe.sv
// Read-return pipe: delays the RAM read enable by the RAM latency and registers
// the returning word together with its valid qualifier.
module avl_rd_pipe
    import avl_burst_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              re_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic [RD_LATENCY-1:0] vld_sr_q, vld_sr_d;
    logic                  rd_vld_q, rd_vld_d;
    logic [DATA_W-1:0]     rd_data_q, rd_data_d;

    // Tail of the shift register marks the cycle the RAM word is on rdata_i.
    always_comb begin
        vld_sr_d  = RD_LATENCY'({vld_sr_q, re_i});
        rd_vld_d  = vld_sr_q[RD_LATENCY-1];
        rd_data_d = vld_sr_q[RD_LATENCY-1] ? rdata_i : rd_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr_q  <= '0;
            rd_vld_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            vld_sr_q  <= vld_sr_d;
            rd_vld_q  <= rd_vld_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign valid_o = rd_vld_q;
    assign data_o  = rd_data_q;

endmodule

// File: rtl/avl_burst_responder.sv
// Avalon-MM bursting slave: splits write/read bursts into per-word accesses on a
// synchronous single-port RAM and returns read data in order.
module avl_burst_responder
    import avl_burst_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int RD_LATENCY = 1,
    parameter int MAX_BURST  = 16
) (
    input  logic                  iCLK,
    input  logic                  iRESETn,
    input  logic [31:0]           iADDRESS,
    input  logic                  iWRITE,
    input  logic                  iREAD,
    input  logic [DATA_W-1:0]     iWRITE_DATA,
    input  logic [BURST_W-1:0]    iBURST_COUNT,
    output logic [DATA_W-1:0]     oREAD_DATA,
    output logic                  oREAD_DATA_VALID,
    output logic                  oWAIT_REQUEST,
    output logic [ADDR_WIDTH-1:0] oMEM_ADDR,
    output logic                  oMEM_WE,
    output logic [DATA_W-1:0]     oMEM_WDATA,
    output logic                  oMEM_RE,
    input  logic [DATA_W-1:0]     iMEM_RDATA,
    output logic                  oPROTO_ERR
);

    logic [1:0]            rst_sync_q, rst_sync_d;
    logic                  rst_int_n;
    logic [1:0]            state_q, state_d;
    logic [BURST_W-1:0]    remaining_q, remaining_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
    logic                  mem_we_q, mem_we_d;
    logic                  mem_re_q, mem_re_d;
    logic                  err_q, err_d;
    logic [BURST_W-1:0]    cnt_norm;
    logic                  cnt_over;
    logic                  rd_last;
    logic                  start_rd;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic                  unused_addr_bits;

    assign cmd_addr         = iADDRESS[ADDR_WIDTH-1:0];
    assign unused_addr_bits = ^iADDRESS[31:ADDR_WIDTH];

    // Reset asserts asynchronously but releases two clocks later, in step with iCLK.
    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) rst_sync_q <= '0;
        else          rst_sync_q <= rst_sync_d;
    end
    assign rst_int_n = rst_sync_q[1];

    always_comb begin
        cnt_over = 1'b0;
        cnt_norm = iBURST_COUNT;
        if (iBURST_COUNT == '0) begin
            cnt_norm = BURST_W'(1);
        end else if (int'(iBURST_COUNT) > MAX_BURST) begin
            cnt_norm = BURST_W'(MAX_BURST);
            cnt_over = 1'b1;
        end
    end

    // The final issue cycle drops waitrequest for a read so bursts chain with no bubble.
    assign rd_last       = (state_q == ST_RD_ISSUE) && (remaining_q == BURST_W'(1));
    assign start_rd      = iREAD && !iWRITE && ((state_q == ST_IDLE) || rd_last);
    assign oWAIT_REQUEST = !rst_int_n || ((state_q == ST_RD_ISSUE) && !(rd_last && !iWRITE));

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        err_d       = err_q;
        case (state_q)
            ST_IDLE: begin
                if (iWRITE) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = cmd_addr;
                    mem_wdata_d = iWRITE_DATA;
                    addr_d      = cmd_addr + 1'b1;
                    remaining_d = cnt_norm - 1'b1;
                    if (cnt_norm != BURST_W'(1)) state_d = ST_WR_BURST;
                    if (iREAD || cnt_over) err_d = 1'b1;
                end
            end
            ST_WR_BURST: begin
                if (iREAD) err_d = 1'b1;
                if (iWRITE) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = iWRITE_DATA;
                    addr_d      = addr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == BURST_W'(1)) state_d = ST_IDLE;
                end
            end
            ST_RD_ISSUE: begin
                mem_re_d    = 1'b1;
                mem_addr_d  = addr_q;
                addr_d      = addr_q + 1'b1;
                remaining_d = remaining_q - 1'b1;
                if (rd_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (start_rd) begin
            addr_d      = cmd_addr;
            remaining_d = cnt_norm;
            state_d     = ST_RD_ISSUE;
            if (cnt_over) err_d = 1'b1;
        end
    end

    always_ff @(posedge iCLK or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            addr_q      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            err_q       <= err_d;
        end
    end

    assign oMEM_ADDR  = mem_addr_q;
    assign oMEM_WDATA = mem_wdata_q;
    assign oMEM_WE    = mem_we_q;
    assign oMEM_RE    = mem_re_q;
    assign oPROTO_ERR = err_q;

    avl_rd_pipe #(
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_pipe (
        .clk     (iCLK),
        .rst_n   (rst_int_n),
        .re_i    (mem_re_q),
        .rdata_i (iMEM_RDATA),
        .valid_o (oREAD_DATA_VALID),
        .data_o  (oREAD_DATA)
    );

endmodule

// File: tb/tb_avl_burst_responder.sv
// Bench for avl_burst_responder: directed and random bursts against a word-array
// reference memory with an expected read-data queue.
module tb_avl_burst_responder;

    localparam int AW    = 10;
    localparam int RDL   = 1;
    localparam int MAXB  = 16;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [31:0]   addr = '0;
    logic          wr = 1'b0;
    logic          rd = 1'b0;
    logic [31:0]   wdata = '0;
    logic [4:0]    bcnt = '0;
    logic [31:0]   oREAD_DATA;
    logic          oREAD_DATA_VALID;
    logic          oWAIT_REQUEST;
    logic [AW-1:0] oMEM_ADDR;
    logic          oMEM_WE;
    logic [31:0]   oMEM_WDATA;
    logic          oMEM_RE;
    logic [31:0]   ram_rdata = '0;
    logic          oPROTO_ERR;

    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [31:0]   pl_data = '0;
    logic [31:0]   ram [0:DEPTH-1];
    logic [31:0]   ref_mem [0:DEPTH-1];

    logic [31:0]   rd_obs[$];
    int            rd_cyc[$];
    logic [31:0]   exp_rd[$];
    logic [AW-1:0] wr_obs_a[$];
    logic [31:0]   wr_obs_d[$];
    logic [AW-1:0] wr_exp_a[$];
    logic [31:0]   wr_exp_d[$];

    int cyc = 0;
    int re_cnt = 0;
    int n_chk = 0;
    int n_pass = 0;

    avl_burst_responder #(.ADDR_WIDTH(AW), .RD_LATENCY(RDL), .MAX_BURST(MAXB)) dut (
        .iCLK             (clk),
        .iRESETn          (rst_n),
        .iADDRESS         (addr),
        .iWRITE           (wr),
        .iREAD            (rd),
        .iWRITE_DATA      (wdata),
        .iBURST_COUNT     (bcnt),
        .oREAD_DATA       (oREAD_DATA),
        .oREAD_DATA_VALID (oREAD_DATA_VALID),
        .oWAIT_REQUEST    (oWAIT_REQUEST),
        .oMEM_ADDR        (oMEM_ADDR),
        .oMEM_WE          (oMEM_WE),
        .oMEM_WDATA       (oMEM_WDATA),
        .oMEM_RE          (oMEM_RE),
        .iMEM_RDATA       (ram_rdata),
        .oPROTO_ERR       (oPROTO_ERR)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Single-port RAM with one cycle of read latency; preload port used only in reset.
    always @(posedge clk) begin
        if (pl_en) ram[pl_addr] <= pl_data;
        else if (oMEM_WE) ram[oMEM_ADDR] <= oMEM_WDATA;
        if (oMEM_RE) ram_rdata <= ram[oMEM_ADDR];
    end

    always @(negedge clk) begin
        if (oREAD_DATA_VALID) begin
            rd_obs.push_back(oREAD_DATA);
            rd_cyc.push_back(cyc);
        end
        if (oMEM_WE) begin
            wr_obs_a.push_back(oMEM_ADDR);
            wr_obs_d.push_back(oMEM_WDATA);
        end
        if (oMEM_RE) re_cnt <= re_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, observed cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic int beats_of(input logic [4:0] raw);
        if (raw == 5'd0) return 1;
        if (int'(raw) > MAXB) return MAXB;
        return int'(raw);
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(input string tag);
        bit ok = 1'b0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (!oWAIT_REQUEST) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk({tag, "_accept"}, {31'b0, oWAIT_REQUEST}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wr_burst(input logic [31:0] a, input logic [4:0] raw, input logic [31:0] d0,
                            input bit rnd, input int gap_at, input int rd_at);
        int            n = beats_of(raw);
        logic [AW-1:0] wa = a[AW-1:0];
        logic [31:0]   d;
        for (int i = 0; i < n; i++) begin
            d     = rnd ? $urandom : d0 + 32'(i);
            wr    = 1'b1;
            rd    = (i == rd_at);
            wdata = d;
            addr  = (i == 0) ? a : $urandom;
            bcnt  = (i == 0) ? raw : 5'($urandom);
            wr_exp_a.push_back(wa);
            wr_exp_d.push_back(d);
            ref_mem[wa] = d;
            wa = wa + 1'b1;
            wait_accept("wr");
            if (i < n - 1 && (i == gap_at || (rnd && $urandom_range(0, 2) == 0))) begin
                wr = 1'b0;
                rd = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        wr = 1'b0;
        rd = 1'b0;
    endtask

    task automatic rd_burst(input logic [31:0] a, input logic [4:0] raw, output int acc);
        int            n = beats_of(raw);
        logic [AW-1:0] ra = a[AW-1:0];
        for (int i = 0; i < n; i++) begin
            exp_rd.push_back(ref_mem[ra]);
            ra = ra + 1'b1;
        end
        rd   = 1'b1;
        wr   = 1'b0;
        addr = a;
        bcnt = raw;
        wait_accept("rd");
        acc  = cyc;
        rd   = 1'b0;
        addr = $urandom;
        bcnt = 5'($urandom);
    endtask

    task automatic check_reads(input string tag);
        chk({tag, "_rd_count"}, 32'(rd_obs.size()), 32'(exp_rd.size()));
        for (int i = 0; i < rd_obs.size() && i < exp_rd.size(); i++)
            chk({tag, "_rd_data"}, rd_obs[i], exp_rd[i]);
        rd_obs.delete();
        rd_cyc.delete();
        exp_rd.delete();
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_wr_count"}, 32'(wr_obs_a.size()), 32'(wr_exp_a.size()));
        for (int i = 0; i < wr_obs_a.size() && i < wr_exp_a.size(); i++) begin
            chk({tag, "_wr_addr"}, 32'(wr_obs_a[i]), 32'(wr_exp_a[i]));
            chk({tag, "_wr_data"}, wr_obs_d[i], wr_exp_d[i]);
        end
        wr_obs_a.delete();
        wr_obs_d.delete();
        wr_exp_a.delete();
        wr_exp_d.delete();
    endtask

    initial begin
        int acc, acc2, re0, nv;
        bit hit;
        logic [31:0] ra;
        logic [4:0]  rc;

        #3 rst_n = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            pl_en      = 1'b1;
            pl_addr    = AW'(i);
            pl_data    = (i >= 16 && i < 32) ? 32'h100 + 32'(i - 16) : $urandom;
            ref_mem[i] = pl_data;
            @(posedge clk);
            #1;
        end
        pl_en = 1'b0;

        chk("rst_wait", {31'b0, oWAIT_REQUEST}, 32'd1);
        chk("rst_rvalid", {31'b0, oREAD_DATA_VALID}, 32'd0);
        chk("rst_rdata", oREAD_DATA, 32'd0);
        chk("rst_we", {31'b0, oMEM_WE}, 32'd0);
        chk("rst_re", {31'b0, oMEM_RE}, 32'd0);
        chk("rst_addr", 32'(oMEM_ADDR), 32'd0);
        chk("rst_wdata", oMEM_WDATA, 32'd0);
        chk("rst_err", {31'b0, oPROTO_ERR}, 32'd0);
        rst_n = 1'b1;
        idle(4);
        chk("idle_wait", {31'b0, oWAIT_REQUEST}, 32'd0);

        // Single write: RAM strobe registered the cycle after the beat.
        wr_burst(32'h0000_0005, 5'd1, 32'hDEAD_BEEF, 1'b0, -1, -1);
        chk("sw_we", {31'b0, oMEM_WE}, 32'd1);
        chk("sw_addr", 32'(oMEM_ADDR), 32'd5);
        chk("sw_wdata", oMEM_WDATA, 32'hDEAD_BEEF);
        chk("sw_wait", {31'b0, oWAIT_REQUEST}, 32'd0);
        idle(4);
        check_writes("sw");

        wr_burst(32'h0000_03FE, 5'd4, 32'd1, 1'b0, 1, -1);
        idle(4);
        check_writes("wrap_wr");
        chk("wrap_wr_err", {31'b0, oPROTO_ERR}, 32'd0);

        re0 = re_cnt;
        rd_burst(32'h10, 5'd16, acc);
        chk("rd16_wait", {31'b0, oWAIT_REQUEST}, 32'd1);
        idle(24);
        chk("rd16_re_count", 32'(re_cnt - re0), 32'd16);
        for (int i = 0; i < rd_cyc.size(); i++)
            chk("rd16_cycle", 32'(rd_cyc[i]), 32'(acc + RDL + 2 + i));
        check_reads("rd16");

        rd_burst(32'h20, 5'd2, acc);
        rd_burst(32'h40, 5'd3, acc2);
        idle(16);
        for (int i = 0; i < rd_cyc.size(); i++)
            chk("b2b_cycle", 32'(rd_cyc[i]), 32'(acc + RDL + 2 + i));
        check_reads("b2b");

        rd_burst(32'hFFFF_FFFF, 5'd3, acc);
        rd_burst(32'h0000_0200, 5'd0, acc);
        idle(12);
        check_reads("wrap_rd");

        for (int t = 0; t < 12; t++) begin
            ra = $urandom;
            rc = 5'($urandom_range(0, 16));
            if ($urandom_range(0, 1) == 1) wr_burst(ra, rc, 32'd0, 1'b1, -1, -1);
            else rd_burst(ra, rc, acc);
        end
        idle(30);
        check_writes("rnd");
        check_reads("rnd");
        chk("rnd_err", {31'b0, oPROTO_ERR}, 32'd0);

        // Read raised during a write burst must be dropped and flagged.
        re0 = re_cnt;
        wr_burst(32'h80, 5'd4, 32'hA0, 1'b0, -1, 1);
        idle(8);
        chk("perr_re_count", 32'(re_cnt - re0), 32'd0);
        chk("perr_err", {31'b0, oPROTO_ERR}, 32'd1);
        check_writes("perr");
        check_reads("perr");
        idle(10);
        chk("perr_sticky", {31'b0, oPROTO_ERR}, 32'd1);

        re0 = re_cnt;
        hit = 1'b0;
        rd_burst(32'h10, 5'd16, acc);
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            #1;
            if (re_cnt - re0 >= 5) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) chk("rst_mid_re", 32'(re_cnt - re0), 32'd5);
        rst_n = 1'b0;
        #1;
        chk("rstm_wait", {31'b0, oWAIT_REQUEST}, 32'd1);
        chk("rstm_rvalid", {31'b0, oREAD_DATA_VALID}, 32'd0);
        chk("rstm_rdata", oREAD_DATA, 32'd0);
        chk("rstm_re", {31'b0, oMEM_RE}, 32'd0);
        chk("rstm_addr", 32'(oMEM_ADDR), 32'd0);
        chk("rstm_err", {31'b0, oPROTO_ERR}, 32'd0);
        nv = rd_obs.size();
        idle(3);
        rst_n = 1'b1;
        idle(8);
        chk("rstm_no_stray", 32'(rd_obs.size()), 32'(nv));
        rd_obs.delete();
        rd_cyc.delete();
        exp_rd.delete();
        rd_burst(32'h33, 5'd1, acc);
        idle(8);
        check_reads("post_rst");
        chk("post_rst_err", {31'b0, oPROTO_ERR}, 32'd0);

        rd_burst(32'h100, 5'd20, acc);
        idle(30);
        check_reads("clamp");
        chk("clamp_err", {31'b0, oPROTO_ERR}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
